// File: rtl/sysid_checker.sv
// sysid_checker: Avalon-MM master that reads the system-ID slave and checks it; optional read timeout via SYSID_CHECKER_TIMEOUT_EN
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1300963752,
  parameter bit          AUTO_START         = 1'b1,
  parameter int          TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] timestamp_value
);
  typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, FIN} state_t;
  state_t state, nxt;
  logic armed, accept, expire;
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end
  assign busy        = state == RD_ID || state == RD_TS;
  assign avm_read    = busy;
  assign avm_address = state == RD_TS;
  assign accept      = busy && !avm_waitrequest;
`ifdef SYSID_CHECKER_TIMEOUT_EN
  logic [15:0] cnt;
  assign expire = busy && avm_waitrequest && cnt == 16'(TIMEOUT_CYCLES);
  // stall counter restarts whenever the FSM changes state, so each read gets a fresh budget
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else cnt <= (nxt != state) ? '0 : (busy && avm_waitrequest) ? cnt + 16'd1 : cnt;
  // sticky abandoned-read flag, cleared only by a new check from FIN
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) timeout <= 1'b0;
    else timeout <= expire ? 1'b1 : (state == FIN && start) ? 1'b0 : timeout;
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif
  // state register
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= nxt;
  // next-state logic; start is only looked at in IDLE and FIN, so it is ignored while busy
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = (start || armed) ? RD_ID : IDLE;
      RD_ID:   nxt = expire ? FIN : accept ? RD_TS : RD_ID;
      RD_TS:   nxt = (expire || accept) ? FIN : RD_TS;
      FIN:     nxt = start ? RD_ID : FIN;
      default: nxt = IDLE;
    endcase
  end
  // captured words and sticky verdict flags; armed launches the auto check on the first edge after reset
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      armed           <= AUTO_START;
      done            <= 1'b0;
      pass            <= 1'b0;
      id_value        <= '0;
      timestamp_value <= '0;
    end else begin
      armed <= 1'b0;
      if (state == FIN && start) begin
        done <= 1'b0;
        pass <= 1'b0;
      end
      if (expire) begin
        done <= 1'b1;
        pass <= 1'b0;
      end else if (accept && state == RD_ID) begin
        id_value <= avm_readdata;
      end else if (accept && state == RD_TS) begin
        timestamp_value <= avm_readdata;
        pass            <= id_value == EXPECTED_ID && avm_readdata == EXPECTED_TIMESTAMP;
        done            <= 1'b1;
      end
    end
endmodule

// File: tb/tb_sysid_checker.sv
// tb_sysid_checker: directed table-driven bench for sysid_checker with a simple system-ID slave model
module tb_sysid_checker;
  localparam logic [31:0] TS = 32'd1300963752;
  logic clock = 1'b0, reset_n = 1'b0, start = 1'b0, avm_waitrequest = 1'b0;
  logic avm_address, avm_read, busy, done, pass, timeout;
  logic [31:0] avm_readdata, id_value, timestamp_value;
  logic [31:0] id_word = 32'd0, ts_word = TS;
  int checks = 0, fails = 0;
  typedef struct {logic [31:0] id; logic [31:0] ts; logic p;} vec_t;
  vec_t vecs[6];

  always #5 clock = ~clock;
  assign avm_readdata = avm_address ? ts_word : id_word;

  sysid_checker #(.TIMEOUT_CYCLES(4)) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .id_value(id_value), .timestamp_value(timestamp_value)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max);
    int n = 0;
    while (!done && n < max) begin
      @(negedge clock);
      n++;
    end
    chk("done_wait", {31'd0, done}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{32'd0, TS, 1'b1};
    vecs[1] = '{32'd0, TS + 32'd1, 1'b0};
    vecs[2] = '{32'd1, TS, 1'b0};
    vecs[3] = '{32'h8000_0000, TS, 1'b0};
    vecs[4] = '{32'd0, TS ^ 32'h8000_0000, 1'b0};
    vecs[5] = '{32'd0, TS, 1'b1};
    tick(2);
    chk("rst_read", {31'd0, avm_read}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_pass", {31'd0, pass}, 0);
    chk("rst_timeout", {31'd0, timeout}, 0);
    chk("rst_id", id_value, 0);
    chk("rst_ts", timestamp_value, 0);
    reset_n = 1'b1;
    tick(1);
    chk("auto_read", {31'd0, avm_read}, 1);
    chk("auto_addr0", {31'd0, avm_address}, 0);
    tick(1);
    chk("auto_addr1", {31'd0, avm_address}, 1);
    chk("auto_done_early", {31'd0, done}, 0);
    tick(1);
    chk("auto_done", {31'd0, done}, 1);
    chk("auto_pass", {31'd0, pass}, 1);
    chk("auto_ts", timestamp_value, TS);
    chk("auto_busy", {31'd0, busy}, 0);
    for (int i = 0; i < 6; i++) begin
      id_word = vecs[i].id;
      ts_word = vecs[i].ts;
      pulse();
      chk("vec_busy", {31'd0, busy}, 1);
      chk("vec_done_clr", {31'd0, done}, 0);
      chk("vec_addr0", {31'd0, avm_address}, 0);
      tick(1);
      chk("vec_addr1", {31'd0, avm_address}, 1);
      chk("vec_read", {31'd0, avm_read}, 1);
      tick(2);
      chk("vec_done", {31'd0, done}, 1);
      chk("vec_pass", {31'd0, pass}, {31'd0, vecs[i].p});
      chk("vec_timeout", {31'd0, timeout}, 0);
      chk("vec_id", id_value, vecs[i].id);
      chk("vec_ts", timestamp_value, vecs[i].ts);
      chk("vec_idle", {31'd0, busy}, 0);
    end
    id_word = 32'd0;
    ts_word = TS;
    avm_waitrequest = 1'b1;
    pulse();
    for (int i = 0; i < 5; i++) begin
      chk("stall_read", {31'd0, avm_read}, 1);
      chk("stall_addr", {31'd0, avm_address}, 0);
      if (i == 4) avm_waitrequest = 1'b0;
      tick(1);
    end
    chk("stall_rdts", {31'd0, avm_address}, 1);
    chk("stall_done_early", {31'd0, done}, 0);
    tick(3);
    chk("stall_done", {31'd0, done}, 1);
    chk("stall_pass", {31'd0, pass}, 1);
    avm_waitrequest = 1'b1;
    pulse();
    tick(1);
    pulse();
    avm_waitrequest = 1'b0;
    wait_done(10);
    chk("busy_start_pass", {31'd0, pass}, 1);
    tick(3);
    chk("busy_start_ignored", {31'd0, busy}, 0);
    chk("busy_start_done", {31'd0, done}, 1);
    pulse();
    chk("fin_start_clr", {31'd0, done}, 0);
    chk("fin_start_busy", {31'd0, busy}, 1);
    wait_done(10);
    chk("fin_start_pass", {31'd0, pass}, 1);
    id_word = 32'h1234;
    pulse();
    tick(1);
    avm_waitrequest = 1'b1;
    chk("rts_addr", {31'd0, avm_address}, 1);
    chk("rts_id", id_value, 32'h1234);
    tick(2);
    chk("rts_read", {31'd0, avm_read}, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_read", {31'd0, avm_read}, 0);
    chk("arst_busy", {31'd0, busy}, 0);
    chk("arst_done", {31'd0, done}, 0);
    chk("arst_pass", {31'd0, pass}, 0);
    chk("arst_timeout", {31'd0, timeout}, 0);
    chk("arst_id", id_value, 0);
    chk("arst_ts", timestamp_value, 0);
    id_word = 32'd0;
    avm_waitrequest = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    tick(1);
    chk("rerun_read", {31'd0, avm_read}, 1);
    chk("rerun_addr0", {31'd0, avm_address}, 0);
    tick(1);
    chk("rerun_addr1", {31'd0, avm_address}, 1);
    tick(1);
    chk("rerun_done", {31'd0, done}, 1);
    chk("rerun_pass", {31'd0, pass}, 1);
`ifdef SYSID_CHECKER_TIMEOUT_EN
    avm_waitrequest = 1'b1;
    pulse();
    n = 0;
    while (avm_read && n < 20) begin
      n++;
      tick(1);
    end
    chk("to_stall_len", {31'd0, n >= 4 && n <= 5}, 1);
    chk("to_read", {31'd0, avm_read}, 0);
    chk("to_done", {31'd0, done}, 1);
    chk("to_flag", {31'd0, timeout}, 1);
    chk("to_pass", {31'd0, pass}, 0);
    avm_waitrequest = 1'b0;
    pulse();
    chk("to_clr", {31'd0, timeout}, 0);
    wait_done(10);
    chk("to_rerun_pass", {31'd0, pass}, 1);
    chk("to_rerun_flag", {31'd0, timeout}, 0);
`else
    n = 0;
    chk("no_timeout", {31'd0, timeout}, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
